packet_ram_arbiter: RTL and testbench

- Shares the single-port packet buffer RAM among three requesters: the VGA pixel reader (read-only), the Ethernet RX writer and the Ethernet TX/crypto reader.
- The video reader has priority so pixel timing is preserved. Network traffic uses video idle cycles (blanking), plus a bounded starvation override.
- Read data returns through a tag pipeline matched to the RAM latency. Each requester sees its own ready/valid.

---
 rtl/packet_ram_arbiter_pkg.sv | 33 +++
 rtl/packet_ram_arbiter_tag_pipe.sv | 30 +++
 rtl/packet_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_packet_ram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_ram_arbiter_pkg.sv
// Shared constants, tag encodings and grant types
// for the packet buffer RAM arbiter.
package packet_ram_arbiter_pkg;

  localparam int PACKET_BUFFER_SIZE      = 4096;
  localparam int COLOR_LEN               = 12;
  localparam int VIDEO_CACHE_RAM_LATENCY = 2;
  localparam int DEF_STARVE_LIMIT        = 16;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_NET  = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } gnt_e;

  // Network side choice: a lone request wins,
  // otherwise rr=0 favours the write.
  function automatic logic pick_wr(
    input logic wr,
    input logic rd,
    input logic rr
  );
    return wr & (~rd | ~rr);
  endfunction

endpackage

// File: rtl/packet_ram_arbiter_tag_pipe.sv
// Fixed-depth shift register that carries read tags
// alongside the RAM read latency.
module arb_tag_pipe #(
  parameter int W     = 2,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/packet_ram_arbiter.sv
// Single-port packet RAM arbiter: video first, network
// round-robin in idle slots, bounded starvation override.
module packet_ram_arbiter
  import packet_ram_arbiter_pkg::*;
#(
  parameter int RAM_SIZE     = PACKET_BUFFER_SIZE,
  parameter int DATA_WIDTH   = COLOR_LEN,
  parameter int LATENCY      = VIDEO_CACHE_RAM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int AW = $clog2(RAM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [AW-1:0]         vid_addr,
  output logic                  vid_ready,
  output logic [DATA_WIDTH-1:0] vid_val,
  input  logic                  wr_req,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int SW =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  localparam bit OVR_EN = (STARVE_LIMIT != 0);

  logic          rr_q, rr_d;
  logic [SW-1:0] starve_q, starve_d;

  logic net_pend;
  logic ovr;
  logic sel_wr;
  logic take_ovr, take_vid, take_net;
  gnt_e gnt;
  tag_e tag_d;
  logic [1:0] tag_out;
  logic net_gnt;

  assign net_pend = wr_req | rd_req;
  assign ovr = OVR_EN & (starve_q == LIM) & net_pend;
  assign sel_wr = pick_wr(wr_req, rd_req, rr_q);

  // Mutually exclusive slot owners, gated by reset.
  assign take_ovr = reset & ovr;
  assign take_vid = reset & ~ovr & vid_req;
  assign take_net = reset & ~ovr & ~vid_req & net_pend;

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      take_ovr,
      take_net: gnt = sel_wr ? GNT_WR : GNT_RD;
      take_vid: gnt = GNT_VID;
      default:  gnt = GNT_NONE;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    tag_d     = TAG_NONE;
    unique case (gnt)
      GNT_VID: begin
        ram_addr = vid_addr;
        tag_d    = TAG_VID;
      end
      GNT_WR: begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
        wr_ack    = 1'b1;
      end
      GNT_RD: begin
        ram_addr = rd_addr;
        rd_ack   = 1'b1;
        tag_d    = TAG_NET;
      end
      default: ;
    endcase
  end

  assign net_gnt = wr_ack | rd_ack;

  always_comb begin
    rr_d     = rr_q;
    starve_d = starve_q;
    if (net_gnt) begin
      rr_d     = ~rr_q;
      starve_d = '0;
    end else if (net_pend && starve_q != LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      rr_q     <= rr_d;
      starve_q <= starve_d;
    end
  end

  arb_tag_pipe #(
    .W     (2),
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (tag_d),
    .q_o    (tag_out)
  );

  assign vid_ready = (tag_out == TAG_VID);
  assign rd_valid  = (tag_out == TAG_NET);
  assign vid_val   = vid_ready ? ram_rdata : '0;
  assign rd_data   = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_packet_ram_arbiter.sv
// Directed and randomized checks of the packet RAM
// arbiter against a cycle-level reference model.
module tb_packet_ram_arbiter;

  localparam int RS  = 64;
  localparam int AW  = 6;
  localparam int DW  = 12;
  localparam int LAT = 2;
  localparam int LIM = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, vid_req, wr_req, rd_req, load;
  logic [AW-1:0] vid_addr, wr_addr, rd_addr;
  logic [DW-1:0] wr_data, ram_rdata;
  logic          vid_ready, wr_ack, rd_ack, rd_valid, ram_we;
  logic [DW-1:0] vid_val, rd_data, ram_wdata;
  logic [AW-1:0] ram_addr;

  logic          z_vid_ready, z_wr_ack, z_rd_ack;
  logic          z_rd_valid, z_ram_we;
  logic [DW-1:0] z_vid_val, z_rd_data, z_ram_wdata;
  logic [AW-1:0] z_ram_addr;
  logic [DW-1:0] zero_rdata;
  assign zero_rdata = '0;

  packet_ram_arbiter #(
    .RAM_SIZE(RS), .DATA_WIDTH(DW),
    .LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_ready(vid_ready), .vid_val(vid_val),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Same stimulus, override disabled.
  packet_ram_arbiter #(
    .RAM_SIZE(RS), .DATA_WIDTH(DW),
    .LATENCY(LAT), .STARVE_LIMIT(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_ready(z_vid_ready), .vid_val(z_vid_val),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(z_wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(z_rd_ack), .rd_valid(z_rd_valid),
    .rd_data(z_rd_data), .ram_addr(z_ram_addr),
    .ram_we(z_ram_we), .ram_wdata(z_ram_wdata),
    .ram_rdata(zero_rdata)
  );

  logic [DW-1:0] mem   [RS];
  logic [DW-1:0] rpipe [LAT];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < RS; i++) mem[i] <= DW'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[LAT-1];

  typedef struct {
    int            due;
    bit            vid;
    logic [DW-1:0] d;
  } ret_t;

  ret_t          m_q[$];
  logic [DW-1:0] ref_mem [RS];
  int            m_starve = 0;
  bit            m_rr = 0;
  int            cyc = 0;
  int            last_who = 0;
  int            n_vec = 0;
  int            n_bad = 0;

  logic          o_vid_ready, o_wr_ack, o_rd_ack;
  logic          o_rd_valid, o_z_wr_ack;
  logic [DW-1:0] o_vid_val, o_rd_data;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  // who: 0 idle, 1 video, 2 net write, 3 net read
  task automatic step();
    bit            net;
    bit            ovr;
    int            who;
    logic [AW-1:0] ea;
    bit            evr, erv;
    logic [DW-1:0] evv, erd;
    ret_t          r;
    @(negedge clk);
    net = 0; who = 0; evr = 0; erv = 0;
    evv = '0; erd = '0; ea = '0;
    if (!reset) begin
      m_q.delete();
      m_starve = 0;
      m_rr = 0;
    end else begin
      net = wr_req || rd_req;
      ovr = (LIM != 0) && (m_starve == LIM) && net;
      if (net && (ovr || !vid_req))
        who = (wr_req && (!rd_req || !m_rr)) ? 2 : 3;
      else if (vid_req)
        who = 1;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        r = m_q.pop_front();
        if (r.vid) begin evr = 1; evv = r.d; end
        else begin erv = 1; erd = r.d; end
      end
    end
    if (who == 1) ea = vid_addr;
    if (who == 2) ea = wr_addr;
    if (who == 3) ea = rd_addr;
    chk("ram_we", 32'(ram_we), 32'(who == 2));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_wdata", 32'(ram_wdata),
        (who == 2) ? 32'(wr_data) : 32'd0);
    chk("wr_ack", 32'(wr_ack), 32'(who == 2));
    chk("rd_ack", 32'(rd_ack), 32'(who == 3));
    chk("vid_ready", 32'(vid_ready), 32'(evr));
    chk("vid_val", 32'(vid_val), 32'(evv));
    chk("rd_valid", 32'(rd_valid), 32'(erv));
    chk("rd_data", 32'(rd_data), 32'(erd));
    if (who == 1)
      m_q.push_back('{due: cyc + LAT, vid: 1'b1,
                      d: ref_mem[vid_addr]});
    if (who == 3)
      m_q.push_back('{due: cyc + LAT, vid: 1'b0,
                      d: ref_mem[rd_addr]});
    if (who == 2) ref_mem[wr_addr] = wr_data;
    if (who >= 2) begin
      m_starve = 0;
      m_rr = !m_rr;
    end else if (net) begin
      m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
    end
    o_vid_ready = vid_ready; o_vid_val = vid_val;
    o_wr_ack = wr_ack;       o_rd_ack = rd_ack;
    o_rd_valid = rd_valid;   o_rd_data = rd_data;
    o_z_wr_ack = z_wr_ack;
    last_who = who;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    bit first_wr;
    bit vmode;
    reset = 0; load = 1;
    vid_req = 0; wr_req = 0; rd_req = 0;
    vid_addr = '0; wr_addr = '0; rd_addr = '0;
    wr_data = '0;
    for (int i = 0; i < RS; i++) ref_mem[i] = DW'(i);
    @(posedge clk);
    #1;
    load = 0;
    step(); step();
    reset = 1;

    // video streaming from preloaded RAM
    vid_req = 1;
    for (int i = 0; i < 32; i++) begin
      vid_addr = AW'(i);
      step();
      if (i == LAT) begin
        chk("t1_first_rdy", 32'(o_vid_ready), 32'd1);
        chk("t1_first_val", 32'(o_vid_val), 32'd0);
      end
      if (i == 31) chk("t1_last_val", 32'(o_vid_val), 32'd29);
      chk("t1_no_wack", 32'(o_wr_ack), 32'd0);
    end
    vid_req = 0;
    step(); step();

    // same-address write and read, write favoured
    wr_req = 1; wr_addr = 5; wr_data = 12'h00A;
    rd_req = 1; rd_addr = 5;
    step();
    chk("t2_wack0", 32'(o_wr_ack), 32'd1);
    wr_req = 0;
    step();
    chk("t2_rack1", 32'(o_rd_ack), 32'd1);
    rd_req = 0;
    step();
    step();
    chk("t2_rvalid3", 32'(o_rd_valid), 32'd1);
    chk("t2_rdata3", 32'(o_rd_data), 32'h00A);

    // starvation override under continuous video
    first = -1;
    vid_req = 1;
    wr_req = 1; wr_addr = 40; wr_data = 12'h055;
    for (int i = 0; i < 24; i++) begin
      vid_addr = AW'(i);
      step();
      if (o_wr_ack && first < 0) first = i;
      if (o_wr_ack) wr_req = 0;
      if (i == 17 || i == 19)
        chk("t3_vid_on", 32'(o_vid_ready), 32'd1);
      if (i == 18)
        chk("t3_vid_gap", 32'(o_vid_ready), 32'd0);
    end
    chk("t3_ack_cyc", 32'(first), 32'd16);

    // override disabled: network waits for idle video
    reset = 0;
    step();
    reset = 1;
    wr_req = 1; wr_addr = 41;
    for (int i = 0; i < 100; i++) begin
      vid_addr = AW'($urandom_range(0, RS - 1));
      wr_data = DW'(i);
      step();
      chk("t4_hold", 32'(o_z_wr_ack), 32'd0);
    end
    vid_req = 0;
    step();
    chk("t4_idle_ack", 32'(o_z_wr_ack), 32'd1);
    wr_req = 0;
    step(); step();

    // reset with reads in flight and a starved requester
    reset = 0;
    step();
    reset = 1;
    wr_req = 1; wr_addr = 42; wr_data = 12'h111;
    step();
    wr_req = 0;
    vid_req = 1; rd_req = 1; rd_addr = 3;
    for (int i = 0; i < 8; i++) begin
      vid_addr = AW'(10 + i);
      step();
    end
    vid_req = 0;
    reset = 0;
    step();
    chk("t5_rst_rdy", 32'(o_vid_ready), 32'd0);
    reset = 1;
    vid_req = 1;
    wr_req = 1; wr_addr = 43; wr_data = 12'h3C3;
    first = -1; first_wr = 0;
    for (int i = 0; i < 20; i++) begin
      vid_addr = AW'(20 + i);
      step();
      if ((o_wr_ack || o_rd_ack) && first < 0) begin
        first = i;
        first_wr = o_wr_ack;
      end
      if (o_wr_ack) wr_req = 0;
      if (o_rd_ack) rd_req = 0;
      if (i < LAT) begin
        chk("t5_no_vrdy", 32'(o_vid_ready), 32'd0);
        chk("t5_no_rval", 32'(o_rd_valid), 32'd0);
      end
    end
    chk("t5_ack_cyc", 32'(first), 32'd16);
    chk("t5_wr_first", 32'(first_wr), 32'd1);

    // randomized traffic with occasional resets
    vmode = 1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) vmode = !vmode;
      vid_req = vmode ? ($urandom_range(0, 9) != 0)
                      : ($urandom_range(0, 9) == 0);
      vid_addr = AW'($urandom_range(0, RS - 1));
      if (!wr_req || last_who == 2) begin
        wr_req = ($urandom_range(0, 2) == 0);
        wr_addr = AW'($urandom_range(0, 15));
        wr_data = DW'($urandom);
      end
      if (!rd_req || last_who == 3) begin
        rd_req = ($urandom_range(0, 2) == 0);
        rd_addr = AW'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 249) != 0);
      step();
    end
    reset = 1;
    vid_req = 0; wr_req = 0; rd_req = 0;
    for (int i = 0; i <= LAT; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
